// File: rtl/ecc_core_executor.sv
// Bit-serial GF(2^m) executor behind one core's command/operand/output FIFOs.
// Define ECC_CORE_RED_EN to enable the {A,B} mod P reduction opcode.
module ecc_core_executor #(
  parameter int Data = 256,
  parameter int Mul  = 1,
  parameter int Sqr  = 2,
  parameter int Xor  = 4,
  parameter int Red  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        cmd_data,
  input  logic              cmd_empty,
  output logic              cmd_rd_en,
  input  logic [2*Data-1:0] inp_data,
  input  logic              inp_empty,
  output logic              inp_rd_en,
  input  logic [Data-1:0]   poly,
  input  logic [10:0]       poly_len,
  output logic [Data-1:0]   out_data,
  output logic              out_wr_en,
  input  logic              out_full,
  output logic              busy,
  output logic              err
);

  localparam logic [2:0] OpMul = 3'(Mul);
  localparam logic [2:0] OpSqr = 3'(Sqr);
  localparam logic [2:0] OpXor = 3'(Xor);
  localparam logic [2:0] OpRed = 3'(Red);
  localparam int MW = $clog2(Data + 1);
`ifdef ECC_CORE_RED_EN
  localparam int SW = 2 * Data;
  localparam int CW = $clog2(2 * Data);
`else
  localparam int SW = Data;
  localparam int CW = $clog2(Data);
`endif

  typedef enum logic [1:0] {IDLE, EXEC, WRITE} state_t;

  state_t          state;
  logic [2:0]      op;
  logic [Data-1:0] a_reg;
  logic [Data-1:0] p_reg;
  logic [MW-1:0]   m_reg;
  logic [SW-1:0]   sh;
  logic [Data:0]   acc;
  logic [CW-1:0]   cnt;

  logic [2:0]      opc;
  logic [Data-1:0] a_in;
  logic [Data-1:0] b_in;
  logic            pop;
  logic            known;
  logic            last;
  logic [SW-1:0]   sh_load;
  logic [Data:0]   mstep;
  logic            unused_bits;

  assign opc  = cmd_data[2:0];
  assign a_in = inp_data[2*Data-1:Data];
  assign b_in = inp_data[Data-1:0];
  assign pop  = !rst && state == IDLE
              && !cmd_empty && !inp_empty;

  assign cmd_rd_en = pop;
  assign inp_rd_en = pop;
  assign err       = pop && !known;
  assign out_wr_en = state == WRITE && !out_full;
  assign busy      = state != IDLE;
  assign out_data  = acc[Data-1:0];

  assign unused_bits = ^{cmd_data[7:3], poly_len[10:MW], OpRed};

  always_comb begin
    known = opc == OpMul || opc == OpSqr || opc == OpXor;
`ifdef ECC_CORE_RED_EN
    if (opc == OpRed) known = 1'b1;
`endif
  end

  // Multiplier bits stream MSB-first out of the top of sh.
  always_comb begin
    sh_load = '0;
    sh_load[SW-1 -: Data] = (opc == OpSqr) ? a_in : b_in;
`ifdef ECC_CORE_RED_EN
    if (opc == OpRed) sh_load = inp_data;
`endif
  end

  always_comb begin
    mstep = acc << 1;
    if (mstep[m_reg]) mstep = mstep ^ {1'b0, p_reg};
    if (sh[SW-1]) mstep = mstep ^ {1'b0, a_reg};
  end

`ifdef ECC_CORE_RED_EN
  logic [Data:0] rstep;
  always_comb begin
    rstep = {acc[Data-1:0], sh[SW-1]};
    if (rstep[m_reg]) rstep = rstep ^ {1'b0, p_reg};
  end
`endif

  always_comb begin
    last = cnt == CW'(Data - 1);
    if (op == OpXor) last = 1'b1;
`ifdef ECC_CORE_RED_EN
    if (op == OpRed) last = cnt == CW'(2 * Data - 1);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      op    <= '0;
      a_reg <= '0;
      p_reg <= '0;
      m_reg <= '0;
      sh    <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pop) begin
            op    <= opc;
            a_reg <= a_in;
            p_reg <= poly;
            m_reg <= poly_len[MW-1:0];
            sh    <= sh_load;
            acc   <= '0;
            cnt   <= '0;
            state <= known ? EXEC : WRITE;
          end
        end
        EXEC: begin
          if (op == OpXor)
            acc <= {1'b0, a_reg ^ sh[SW-1 -: Data]};
`ifdef ECC_CORE_RED_EN
          else if (op == OpRed)
            acc <= rstep;
`endif
          else
            acc <= mstep;
          sh  <= sh << 1;
          cnt <= cnt + 1'b1;
          if (last) state <= WRITE;
        end
        WRITE: begin
          if (!out_full) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
